icache_direct: RTL and testbench
================================

Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache sitting between the memory controller and the instruction-fetch stage.
- Accepts one fetch PC at a time from IF and returns one 32-bit instruction word as a single-cycle valid pulse.
- On a miss, fills a 4-word line from the memory controller, one word per response.
- Honors the global rdy stall and the ROB mispredict flush.

Parameters:
- INDEX_BITS, 6, log2 of line count (64 lines).
- LINE_WORDS, 4, 32-bit words per line; fixed at 4, so offset is pc[3:2].

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; when low, all state and outputs hold
- flush  in  1  ROB mispredict/jump redirect (jp_ok); cancels any outstanding fetch
- pc_in  in  32  fetch address from IF
- pc_valid  in  1  IF presents pc_in this cycle (level)
- ins_out  out  32  instruction word for pc_in
- ins_valid  out  1  one-cycle pulse: ins_out is valid
- mem_req  out  1  line-fill request, held until last word returns
- mem_addr  out  32  line-aligned fill address {tag,index,4'b0}
- mem_resp_valid  in  1  memory controller returns one word this cycle
- mem_resp_data  in  32  returned word; words arrive in ascending address order

Behaviour:
- Address split:
  - pc[1:0] ignored.
  - word = pc[3:2].
  - index = pc[3+INDEX_BITS:4].
  - tag = pc[31:4+INDEX_BITS].
- Storage:
  - valid[2^INDEX_BITS], tag array, data array of 2^INDEX_BITS x 4 words.
  - Only valid bits are reset.
- Reset values:
  - All valid=0, state=IDLE, ins_valid=0, ins_out=0, mem_req=0, mem_addr=0, fill counter=0, drop=0.
- rdy=0: no register updates. mem_resp_valid is not accepted (the memory controller shares rdy).
- States: IDLE, FILL, RESP.
- IDLE:
  - pc_valid && !flush && hit: ins_out<=data[index][word], ins_valid<=1 next cycle. Hit latency is 1 cycle.
  - pc_valid && !flush && miss:
    - Latch pc into req_pc.
    - mem_req<=1, mem_addr<=line address, cnt<=0, drop<=0.
    - Go to FILL.
  - flush, or !pc_valid: no request taken; ins_valid<=0.
- FILL:
  - Each mem_resp_valid writes word cnt, then cnt increments.
  - On the 4th word:
    - Set valid and tag for the line; mem_req<=0.
    - Go to RESP with the full line held in a bypass buffer.
  - flush during FILL sets drop=1. The fill still completes and the line is installed (memory transaction is never aborted).
- RESP (1 cycle):
  - If !drop && !flush: ins_out<=requested word from the bypass buffer, ins_valid<=1.
  - Return to IDLE.
  - pc_valid is ignored in RESP. IF holds the PC, so it is re-looked up next IDLE cycle only if IF still requests.
- ins_valid is high for exactly one cycle per delivered instruction and is never high in two consecutive cycles. This matches IF deasserting pc_valid while ins_valid is high.
- flush high while ins_valid is high: IF discards; the cache does nothing special. ins_valid is always 0 the cycle after flush.
- Same-line back-to-back requests after a fill hit with 1-cycle latency.
- Conflict miss evicts silently; there is no write path and no dirty state.
- rst mid-FILL: state returns to IDLE and mem_req drops in the same cycle; the memory controller is reset by the same rst.

Decomposition:
- Shared package/defines:
  - Fill FSM state encodings (IDLE/FILL/RESP).
  - LINE_WORDS, line offset width (4 bits), True/False constants already in defines.v.
- One natural sub-module: icache_data_ram (2^INDEX_BITS x 128-bit storage with 32-bit word write-enable and 1-cycle registered word read).
- Tag/valid arrays and the FSM stay in the top.

Test Plan:
- Cold miss: rst, then pc_in=0x0 pc_valid=1; memory returns 0x00000013, 0x11, 0x22, 0x33 with 1 gap cycle each.
  - mem_req=1 and mem_addr=0x0 until the 4th word.
  - Then ins_valid pulses once with ins_out=0x00000013.
- Hit after fill: pc_in=0x8 → ins_valid next cycle, ins_out=0x22, no mem_req.
- Conflict eviction: fill 0x0, then request 0x400 (same index, INDEX_BITS=6) → new fill at mem_addr=0x400. Re-request 0x0 → miss again.
- Flush mid-fill: request 0x40 and pulse flush after the 2nd response word.
  - Fill completes and ins_valid stays 0.
  - A later request 0x44 hits with 1-cycle latency.
- rdy stall: deassert rdy for 3 cycles mid-FILL while mem_resp_valid toggles.
  - Counter and outputs frozen; the line is correct after rdy returns.
- Reset mid-fill: rst during FILL → mem_req=0 and ins_valid=0 next cycle. A request to the same line misses (valid cleared).

Source files
------------

// File: rtl/icache_direct_pkg.sv
// Shared constants and fill-FSM state encoding for the direct-mapped instruction cache.
// Imported by the cache top and its data RAM.
package icache_direct_pkg;

    localparam int LINE_WORDS  = 4;
    localparam int OFFSET_BITS = 4;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RESP = 2'd2
    } fill_state_t;

endpackage

// File: rtl/icache_direct_data_ram.sv
// Line storage for the instruction cache: one 128-bit row per line, written a
// 32-bit word at a time during fills, read back one word with a registered output.
module icache_data_ram
    import icache_direct_pkg::*;
#(
    parameter int INDEX_BITS = 6
) (
    input  logic                   clk,
    input  logic [LINE_WORDS-1:0]  wr_we,
    input  logic [INDEX_BITS-1:0]  wr_index,
    input  logic [31:0]            wr_data,
    input  logic                   rd_en,
    input  logic [INDEX_BITS-1:0]  rd_index,
    input  logic [1:0]             rd_word,
    output logic [31:0]            rd_data
);
    localparam int LINES = 1 << INDEX_BITS;

    logic [32*LINE_WORDS-1:0] mem [LINES];

    always_ff @(posedge clk) begin
        for (int w = 0; w < LINE_WORDS; w++) begin
            if (wr_we[w]) begin
                mem[wr_index][w*32 +: 32] <= wr_data;
            end
        end
    end

    // Read register only moves on a lookup so the last delivered word stays put.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_index][32*rd_word +: 32];
        end
    end

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: 1-cycle hits, 4-word line fills from
// the memory controller, global rdy stall and mispredict flush.
module icache_direct
    import icache_direct_pkg::*;
#(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    input  logic [31:0] pc_in,
    input  logic        pc_valid,
    output logic [31:0] ins_out,
    output logic        ins_valid,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 32 - OFFSET_BITS - INDEX_BITS;

    fill_state_t state_reg, state_next;
    logic        ins_valid_reg, ins_valid_next;
    logic        out_sel_ram_reg, out_sel_ram_next;
    logic [31:0] out_word_reg, out_word_next;
    logic        mem_req_reg, mem_req_next;
    logic [31:0] mem_addr_reg, mem_addr_next;
    logic [1:0]  cnt_reg, cnt_next;
    logic        drop_reg, drop_next;
    logic [31:0] req_pc_reg, req_pc_next;

    logic [LINES-1:0]    valid_reg;
    logic [TAG_BITS-1:0] tag_mem [LINES];
    logic [31:0]         bypass_reg [LINE_WORDS];

    logic [INDEX_BITS-1:0] pc_index, req_index;
    logic [TAG_BITS-1:0]   pc_tag, req_tag;
    logic [1:0]            pc_word, req_word;
    logic                  hit, take_req, lookup_hit, lookup_miss;
    logic                  resp_fire, last_word, ram_rd_en;
    logic [LINE_WORDS-1:0] fill_we;
    logic [31:0]           ram_rd_data;
    logic                  unused_pc_bits;

    assign pc_index  = pc_in[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
    assign pc_tag    = pc_in[31:OFFSET_BITS+INDEX_BITS];
    assign pc_word   = pc_in[3:2];
    assign req_index = req_pc_reg[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
    assign req_tag   = req_pc_reg[31:OFFSET_BITS+INDEX_BITS];
    assign req_word  = req_pc_reg[3:2];
    assign unused_pc_bits = ^{pc_in[1:0], req_pc_reg[1:0]};

    assign hit = valid_reg[pc_index] && (tag_mem[pc_index] == pc_tag);
    // A request is not taken while a word is being delivered, keeping ins_valid a pulse.
    assign take_req    = (state_reg == ST_IDLE) && pc_valid && !flush && !ins_valid_reg;
    assign lookup_hit  = take_req && hit;
    assign lookup_miss = take_req && !hit;
    assign resp_fire   = (state_reg == ST_FILL) && mem_resp_valid;
    assign last_word   = resp_fire && (cnt_reg == 2'd3);
    assign ram_rd_en   = rdy && !rst && lookup_hit;

    for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_fill_we
        assign fill_we[gi] = rdy && !rst && resp_fire && (cnt_reg == 2'(gi));
    end

    icache_data_ram #(
        .INDEX_BITS(INDEX_BITS)
    ) u_data_ram (
        .clk      (clk),
        .wr_we    (fill_we),
        .wr_index (req_index),
        .wr_data  (mem_resp_data),
        .rd_en    (ram_rd_en),
        .rd_index (pc_index),
        .rd_word  (pc_word),
        .rd_data  (ram_rd_data)
    );

    always_comb begin
        state_next       = state_reg;
        ins_valid_next   = FALSE;
        out_sel_ram_next = out_sel_ram_reg;
        out_word_next    = out_word_reg;
        mem_req_next     = mem_req_reg;
        mem_addr_next    = mem_addr_reg;
        cnt_next         = cnt_reg;
        drop_next        = drop_reg;
        req_pc_next      = req_pc_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (lookup_hit) begin
                    ins_valid_next   = TRUE;
                    out_sel_ram_next = TRUE;
                end else if (lookup_miss) begin
                    req_pc_next   = pc_in;
                    mem_req_next  = TRUE;
                    mem_addr_next = {pc_in[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                    cnt_next      = 2'd0;
                    drop_next     = FALSE;
                    state_next    = ST_FILL;
                end
            end
            ST_FILL: begin
                // The memory transaction always runs to completion; a flush only mutes delivery.
                if (flush) begin
                    drop_next = TRUE;
                end
                if (resp_fire) begin
                    cnt_next = cnt_reg + 2'd1;
                    if (cnt_reg == 2'd3) begin
                        mem_req_next = FALSE;
                        state_next   = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (!drop_reg && !flush) begin
                    ins_valid_next   = TRUE;
                    out_sel_ram_next = FALSE;
                    out_word_next    = bypass_reg[req_word];
                end
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            ins_valid_reg   <= FALSE;
            out_sel_ram_reg <= FALSE;
            out_word_reg    <= 32'd0;
            mem_req_reg     <= FALSE;
            mem_addr_reg    <= 32'd0;
            cnt_reg         <= 2'd0;
            drop_reg        <= FALSE;
            req_pc_reg      <= 32'd0;
            valid_reg       <= '0;
        end else if (rdy) begin
            state_reg       <= state_next;
            ins_valid_reg   <= ins_valid_next;
            out_sel_ram_reg <= out_sel_ram_next;
            out_word_reg    <= out_word_next;
            mem_req_reg     <= mem_req_next;
            mem_addr_reg    <= mem_addr_next;
            cnt_reg         <= cnt_next;
            drop_reg        <= drop_next;
            req_pc_reg      <= req_pc_next;
            if (last_word) begin
                valid_reg[req_index] <= TRUE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rdy && last_word) begin
            tag_mem[req_index] <= req_tag;
        end
        if (!rst && rdy && resp_fire) begin
            bypass_reg[cnt_reg] <= mem_resp_data;
        end
    end

    assign ins_out   = out_sel_ram_reg ? ram_rd_data : out_word_reg;
    assign ins_valid = ins_valid_reg;
    assign mem_req   = mem_req_reg;
    assign mem_addr  = mem_addr_reg;

endmodule

// File: tb/tb_icache_direct.sv
// Bench for icache_direct: directed scenarios plus random fetches, checked against a
// line-level cache model and a backing-memory function.
module tb_icache_direct;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        flush;
    logic [31:0] pc_in;
    logic        pc_valid;
    logic [31:0] ins_out;
    logic        ins_valid;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    int checks = 0;
    int errors = 0;

    bit          model_valid [64];
    logic [21:0] model_tag   [64];
    logic [31:0] seed;

    icache_direct #(.INDEX_BITS(6)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .flush          (flush),
        .pc_in          (pc_in),
        .pc_valid       (pc_valid),
        .ins_out        (ins_out),
        .ins_valid      (ins_valid),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backing memory: the first line holds the cold-miss words, the rest is hashed.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] fixed [4];
        fixed[0] = 32'h0000_0013;
        fixed[1] = 32'h0000_0011;
        fixed[2] = 32'h0000_0022;
        fixed[3] = 32'h0000_0033;
        if (a[31:4] == 28'd0) return fixed[a[3:2]];
        return (a * 32'h9E37_79B1) ^ seed;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic serve_word(input logic [31:0] a);
        mem_resp_valid = 1'b1;
        mem_resp_data  = mem_word(a);
        tick();
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'd0;
    endtask

    task automatic install(input logic [31:0] pc);
        model_valid[pc[9:4]] = 1'b1;
        model_tag[pc[9:4]]   = pc[31:10];
    endtask

    // Present one fetch; expected hit/miss comes from the model, data from backing memory.
    task automatic do_fetch(input logic [31:0] pc, input int gap);
        logic        exp_hit;
        logic [31:0] line;
        logic [31:0] exp_word;
        exp_hit  = model_valid[pc[9:4]] && (model_tag[pc[9:4]] == pc[31:10]);
        line     = {pc[31:4], 4'h0};
        exp_word = mem_word({pc[31:2], 2'b00});
        pc_in    = pc;
        pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
        if (exp_hit) begin
            chk("hit_valid", {31'd0, ins_valid}, 32'd1);
            chk("hit_data", ins_out, exp_word);
            chk("hit_no_req", {31'd0, mem_req}, 32'd0);
        end else begin
            chk("miss_req", {31'd0, mem_req}, 32'd1);
            chk("miss_addr", mem_addr, line);
            for (int w = 0; w < 4; w++) begin
                for (int g = 0; g < gap; g++) begin
                    tick();
                    chk("fill_req_gap", {31'd0, mem_req}, 32'd1);
                end
                chk("fill_addr", mem_addr, line);
                chk("fill_no_ins", {31'd0, ins_valid}, 32'd0);
                serve_word(line + 32'(4 * w));
            end
            chk("fill_req_drop", {31'd0, mem_req}, 32'd0);
            tick();
            chk("resp_valid", {31'd0, ins_valid}, 32'd1);
            chk("resp_data", ins_out, exp_word);
            install(pc);
        end
        tick();
        chk("pulse_end", {31'd0, ins_valid}, 32'd0);
        $display("fetch pc=%h %s word=%h", pc, exp_hit ? "hit " : "miss", exp_word);
    endtask

    initial begin
        logic [31:0] rpc;
        seed           = $urandom;
        rst            = 1'b1;
        rdy            = 1'b1;
        flush          = 1'b0;
        pc_in          = 32'd0;
        pc_valid       = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'd0;
        foreach (model_valid[i]) model_valid[i] = 1'b0;
        tick();
        tick();
        chk("rst_ins_valid", {31'd0, ins_valid}, 32'd0);
        chk("rst_ins_out", ins_out, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        rst = 1'b0;
        tick();

        // Cold miss, then hit in the filled line.
        do_fetch(32'h0000_0000, 1);
        do_fetch(32'h0000_0008, 0);

        // Flush together with a request: nothing is taken.
        pc_in    = 32'h0000_0004;
        pc_valid = 1'b1;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        pc_valid = 1'b0;
        chk("flush_idle_ins", {31'd0, ins_valid}, 32'd0);
        chk("flush_idle_req", {31'd0, mem_req}, 32'd0);
        $display("fetch pc=00000004 with flush: dropped");

        // Conflict eviction on index 0.
        do_fetch(32'h0000_0400, 0);
        do_fetch(32'h0000_0000, 0);

        // Flush mid-fill: the line still installs but nothing is delivered.
        pc_in    = 32'h0000_0040;
        pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
        chk("mflush_req", {31'd0, mem_req}, 32'd1);
        serve_word(32'h40);
        serve_word(32'h44);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        serve_word(32'h48);
        serve_word(32'h4C);
        chk("mflush_req_drop", {31'd0, mem_req}, 32'd0);
        tick();
        chk("mflush_no_resp", {31'd0, ins_valid}, 32'd0);
        tick();
        chk("mflush_no_resp2", {31'd0, ins_valid}, 32'd0);
        install(32'h40);
        $display("fetch pc=00000040 flushed mid-fill");
        do_fetch(32'h0000_0044, 0);

        // rdy stall mid-fill with responses toggling.
        pc_in    = 32'h0000_0080;
        pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
        serve_word(32'h80);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_resp_valid = (i % 2 == 0);
            mem_resp_data  = 32'hDEAD_0000 | 32'(i);
            tick();
            chk("stall_req", {31'd0, mem_req}, 32'd1);
            chk("stall_addr", mem_addr, 32'h80);
            chk("stall_ins", {31'd0, ins_valid}, 32'd0);
        end
        rdy            = 1'b1;
        mem_resp_valid = 1'b0;
        serve_word(32'h84);
        serve_word(32'h88);
        chk("stall_req_hold", {31'd0, mem_req}, 32'd1);
        serve_word(32'h8C);
        chk("stall_req_drop", {31'd0, mem_req}, 32'd0);
        tick();
        chk("stall_resp_valid", {31'd0, ins_valid}, 32'd1);
        chk("stall_resp_data", ins_out, mem_word(32'h80));
        tick();
        install(32'h80);
        $display("fetch pc=00000080 with rdy stall");
        do_fetch(32'h0000_008C, 0);
        do_fetch(32'h0000_0084, 0);

        // Reset in the middle of a fill clears every line.
        pc_in    = 32'h0000_00C0;
        pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
        serve_word(32'hC0);
        serve_word(32'hC4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_req", {31'd0, mem_req}, 32'd0);
        chk("mrst_ins", {31'd0, ins_valid}, 32'd0);
        foreach (model_valid[i]) model_valid[i] = 1'b0;
        $display("fetch pc=000000c0 reset mid-fill");
        do_fetch(32'h0000_00C0, 0);
        do_fetch(32'h0000_0000, 1);

        // Random fetches over a few indices and tags for hits and conflicts.
        for (int n = 0; n < 40; n++) begin
            rpc = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4)
                | (32'($urandom_range(0, 3)) << 2);
            do_fetch(rpc, int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
